// File: rtl/arm_load_store_unit.sv
// Load/store unit for data port 2 of the ARM memory: turns byte/halfword/word requests into word accesses.
// Optional macro ARM_LSU_UNALIGNED_ROTATE_EN: unaligned word loads return the aligned word rotated right.
module arm_load_store_unit #(
    parameter int MEM_ADDR_WIDTH = 30,
    parameter bit BIG_ENDIAN     = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_signed,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      busy,
    output logic                      ack,
    output logic [31:0]               rdata,
    output logic                      fault,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      mem_write,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_excpt
);

    // state   | meaning
    // S_IDLE  | waiting for req; ack pulse from previous request is cleared here
    // S_CHECK | alignment/size check, word address driven on next edge
    // S_READ  | memory word sampled: load extract or store merge
    // S_WRITE | single-cycle memory write
    // S_DONE  | raises ack, drops busy, returns to idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t      state;
    logic        l_write;
    logic [1:0]  l_size;
    logic        l_signed;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;

    logic        addr_fault;
    logic [1:0]  byte_lane;
    logic        half_hi;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] word_val;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // byte_lane indexes bits [8*lane+7:8*lane]; half_hi selects bits [31:16]
    assign byte_lane = BIG_ENDIAN ? ~l_addr[1:0] : l_addr[1:0];
    assign half_hi   = BIG_ENDIAN ? ~l_addr[1]   : l_addr[1];
    assign byte_val  = mem_rdata[{byte_lane, 3'b000} +: 8];
    assign half_val  = half_hi ? mem_rdata[31:16] : mem_rdata[15:0];

`ifdef ARM_LSU_UNALIGNED_ROTATE_EN
    logic [63:0] rot_src;
    assign rot_src  = {mem_rdata, mem_rdata};
    assign word_val = rot_src[{l_addr[1:0], 3'b000} +: 32];
`else
    assign word_val = mem_rdata;
`endif

    always_comb begin
        addr_fault = 1'b0;
        case (l_size)
            SZ_RSVD: addr_fault = 1'b1;
            SZ_HALF: addr_fault = l_addr[0];
`ifdef ARM_LSU_UNALIGNED_ROTATE_EN
            SZ_WORD: addr_fault = l_write && (l_addr[1:0] != 2'b00);
`else
            SZ_WORD: addr_fault = (l_addr[1:0] != 2'b00);
`endif
            default: addr_fault = 1'b0;
        endcase
    end

    always_comb begin
        load_val = word_val;
        case (l_size)
            SZ_BYTE: load_val = {{24{l_signed & byte_val[7]}}, byte_val};
            SZ_HALF: load_val = {{16{l_signed & half_val[15]}}, half_val};
            default: load_val = word_val;
        endcase
    end

    always_comb begin
        merge_val = mem_rdata;
        if (l_size == SZ_BYTE) begin
            merge_val[{byte_lane, 3'b000} +: 8] = l_wdata[7:0];
        end else if (half_hi) begin
            merge_val[31:16] = l_wdata[15:0];
        end else begin
            merge_val[15:0] = l_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            l_write   <= 1'b0;
            l_size    <= 2'b00;
            l_signed  <= 1'b0;
            l_addr    <= '0;
            l_wdata   <= '0;
            busy      <= 1'b0;
            ack       <= 1'b0;
            rdata     <= '0;
            fault     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        l_write  <= req_write;
                        l_size   <= req_size;
                        l_signed <= req_signed;
                        l_addr   <= req_addr;
                        l_wdata  <= req_wdata;
                        busy     <= 1'b1;
                        fault    <= 1'b0;
                        rdata    <= '0;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (addr_fault) begin
                        fault <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        mem_addr <= l_addr[MEM_ADDR_WIDTH+1:2];
                        if (l_write && (l_size == SZ_WORD)) begin
                            mem_wdata <= l_wdata;
                            mem_write <= 1'b1;
                            state     <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (mem_excpt) begin
                        fault <= 1'b1;
                        state <= S_DONE;
                    end else if (!l_write) begin
                        rdata <= load_val;
                        state <= S_DONE;
                    end else begin
                        mem_wdata <= merge_val;
                        mem_write <= 1'b1;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    mem_write <= 1'b0;
                    if (mem_excpt) begin
                        fault <= 1'b1;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    ack   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
